// File: rtl/btb_pkg.sv
// Shared geometry, counter encodings and entry layout for the branch target buffer.
package btb_pkg;
   localparam int SETS    = 8;
   localparam int WAYS    = 2;
   localparam int INDEX_W = $clog2(SETS);
   localparam int TAG_W   = 32 - INDEX_W - 2;

   typedef enum logic [1:0] {
      CTR_SNT = 2'b00,
      CTR_WNT = 2'b01,
      CTR_WT  = 2'b10,
      CTR_ST  = 2'b11
   } ctr_e;

   localparam logic [1:0] CTR_INIT = CTR_WT;

   typedef struct packed {
      logic             valid;
      logic [TAG_W-1:0] tag;
      logic [31:0]      target;
      logic [1:0]       ctr;
   } btb_entry_t;
endpackage

// File: rtl/btb_sat_counter.sv
// 2-bit saturating counter next-value function, used once per way on the update path.
module btb_sat_counter
   import btb_pkg::*;
(
   input  logic [1:0] ctr,
   input  logic       taken,
   output logic [1:0] ctr_next
);
   always_comb begin
      ctr_next = ctr;
      if (taken) begin
         if (ctr != CTR_ST) ctr_next = ctr + 2'd1;
      end else begin
         if (ctr != CTR_SNT) ctr_next = ctr - 2'd1;
      end
   end
endmodule

// File: rtl/branch_target_buffer.sv
// 2-way set-associative BTB: combinational lookup for fetch, registered update from EX.
module branch_target_buffer
   import btb_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] pc,
   output logic        btb_pc_valid,
   output logic        btb_pc_predictTaken,
   output logic [31:0] btb_target_pc,
   input  logic        update_en,
   input  logic [31:0] update_pc,
   input  logic [31:0] update_target,
   input  logic        update_taken
);
   btb_entry_t entry_q [SETS][WAYS];
   btb_entry_t entry_d [SETS][WAYS];
   logic [SETS-1:0] lru_q, lru_d;

   logic [INDEX_W-1:0] idx, uidx;
   logic [TAG_W-1:0]   tag, utag;
   logic [WAYS-1:0]    hit, uhit;
   logic [1:0]         ctr_next [WAYS];
   btb_entry_t         sel;
   logic               hw, victim;

   assign idx  = pc[INDEX_W+1:2];
   assign tag  = pc[31:INDEX_W+2];
   assign uidx = update_pc[INDEX_W+1:2];
   assign utag = update_pc[31:INDEX_W+2];

   for (genvar w = 0; w < WAYS; w++) begin : g_way
      assign hit[w]  = entry_q[idx][w].valid  && (entry_q[idx][w].tag  == tag);
      assign uhit[w] = entry_q[uidx][w].valid && (entry_q[uidx][w].tag == utag);
      btb_sat_counter u_ctr (
         .ctr      (entry_q[uidx][w].ctr),
         .taken    (update_taken),
         .ctr_next (ctr_next[w])
      );
   end

   // Way 0 takes priority on the (unreachable) double hit.
   always_comb begin
      sel                 = hit[0] ? entry_q[idx][0] : entry_q[idx][1];
      btb_pc_valid        = |hit;
      btb_pc_predictTaken = btb_pc_valid && sel.ctr[1];
      btb_target_pc       = btb_pc_valid ? sel.target : 32'h0;
   end

   always_comb begin
      entry_d = entry_q;
      lru_d   = lru_q;
      hw      = ~uhit[0];
      victim  = !entry_q[uidx][0].valid ? 1'b0 :
                !entry_q[uidx][1].valid ? 1'b1 : lru_q[uidx];
      if (update_en) begin
         if (|uhit) begin
            entry_d[uidx][hw].target = update_target;
            entry_d[uidx][hw].ctr    = ctr_next[hw];
            lru_d[uidx]              = ~hw;
         end else if (update_taken) begin
            entry_d[uidx][victim].valid  = 1'b1;
            entry_d[uidx][victim].tag    = utag;
            entry_d[uidx][victim].target = update_target;
            entry_d[uidx][victim].ctr    = CTR_INIT;
            lru_d[uidx]                  = ~victim;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lru_q <= '0;
         for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
               entry_q[s][w] <= '{valid: 1'b0, tag: '0, target: 32'h0, ctr: CTR_WNT};
            end
         end
      end else begin
         lru_q   <= lru_d;
         entry_q <= entry_d;
      end
   end
endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed self-checking bench for branch_target_buffer.
module tb_branch_target_buffer;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] pc;
   logic        btb_pc_valid;
   logic        btb_pc_predictTaken;
   logic [31:0] btb_target_pc;
   logic        update_en;
   logic [31:0] update_pc;
   logic [31:0] update_target;
   logic        update_taken;

   int checks = 0;
   int errors = 0;

   branch_target_buffer dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .pc                  (pc),
      .btb_pc_valid        (btb_pc_valid),
      .btb_pc_predictTaken (btb_pc_predictTaken),
      .btb_target_pc       (btb_target_pc),
      .update_en           (update_en),
      .update_pc           (update_pc),
      .update_target       (update_target),
      .update_taken        (update_taken)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic outs(input string tag, input logic v, input logic t, input logic [31:0] tgt);
      chk({tag, ".valid"},  {31'b0, btb_pc_valid}, {31'b0, v});
      chk({tag, ".taken"},  {31'b0, btb_pc_predictTaken}, {31'b0, t});
      chk({tag, ".target"}, btb_target_pc, tgt);
   endtask

   task automatic look(input string tag, input logic [31:0] a,
                       input logic v, input logic t, input logic [31:0] tgt);
      pc = a;
      #1;
      outs(tag, v, t, tgt);
   endtask

   task automatic upd(input logic [31:0] a, input logic [31:0] tgt, input logic tk);
      @(negedge clk);
      update_en     = 1'b1;
      update_pc     = a;
      update_target = tgt;
      update_taken  = tk;
      @(posedge clk);
      #1;
      update_en = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; pc = 32'h100;
      update_en = 1'b0; update_pc = '0; update_target = '0; update_taken = 1'b0;
      #1;
      outs("reset", 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      upd(32'h100, 32'h200, 1'b1);
      look("alloc", 32'h100, 1'b1, 1'b1, 32'h200);

      // counter walk 10 -> 01 -> 00 -> 00 -> 01 -> 10 -> 11 -> 11 -> 10
      upd(32'h100, 32'h200, 1'b0); look("ctr01", 32'h100, 1'b1, 1'b0, 32'h200);
      upd(32'h100, 32'h200, 1'b0); look("ctr00", 32'h100, 1'b1, 1'b0, 32'h200);
      upd(32'h100, 32'h200, 1'b0); look("ctr00s", 32'h100, 1'b1, 1'b0, 32'h200);
      upd(32'h100, 32'h200, 1'b1); look("ctr01u", 32'h100, 1'b1, 1'b0, 32'h200);
      upd(32'h100, 32'h200, 1'b1); look("ctr10u", 32'h100, 1'b1, 1'b1, 32'h200);
      upd(32'h100, 32'h200, 1'b1); look("ctr11", 32'h100, 1'b1, 1'b1, 32'h200);
      upd(32'h100, 32'h200, 1'b1); look("ctr11s", 32'h100, 1'b1, 1'b1, 32'h200);
      upd(32'h100, 32'h200, 1'b0); look("ctr10d", 32'h100, 1'b1, 1'b1, 32'h200);

      // set 0 replacement
      upd(32'h200, 32'h600, 1'b1); look("way1", 32'h200, 1'b1, 1'b1, 32'h600);
      upd(32'h100, 32'h204, 1'b1); look("hitupd", 32'h100, 1'b1, 1'b1, 32'h204);
      upd(32'h300, 32'h700, 1'b1);
      look("evict200", 32'h200, 1'b0, 1'b0, 32'h0);
      look("keep100", 32'h100, 1'b1, 1'b1, 32'h204);
      look("new300", 32'h300, 1'b1, 1'b1, 32'h700);

      // update_en=0 holds state
      @(negedge clk);
      update_pc = 32'h104; update_target = 32'h800; update_taken = 1'b1;
      @(posedge clk); #1;
      look("noen", 32'h104, 1'b0, 1'b0, 32'h0);
      upd(32'h104, 32'h800, 1'b1); look("set1", 32'h104, 1'b1, 1'b1, 32'h800);

      // not-taken miss allocates nothing
      upd(32'h140, 32'h900, 1'b0);
      look("nt140", 32'h140, 1'b0, 1'b0, 32'h0);
      look("nt100", 32'h100, 1'b1, 1'b1, 32'h204);
      look("nt300", 32'h300, 1'b1, 1'b1, 32'h700);
      look("nt104", 32'h104, 1'b1, 1'b1, 32'h800);

      // lookup during its own first update sees old contents
      @(negedge clk);
      pc = 32'h180;
      update_en = 1'b1; update_pc = 32'h180; update_target = 32'hA00; update_taken = 1'b1;
      #1;
      outs("samecyc", 1'b0, 1'b0, 32'h0);
      @(posedge clk); #1;
      update_en = 1'b0;
      outs("nextcyc", 1'b1, 1'b1, 32'hA00);
      look("lru100", 32'h100, 1'b0, 1'b0, 32'h0);
      look("lru300", 32'h300, 1'b1, 1'b1, 32'h700);

      // async reset mid-cycle drops the pending write
      @(negedge clk);
      pc = 32'h300;
      update_en = 1'b1; update_pc = 32'h3C0; update_target = 32'hB00; update_taken = 1'b1;
      #1;
      rst_n = 1'b0;
      #1;
      outs("asyncrst", 1'b0, 1'b0, 32'h0);
      @(posedge clk); #1;
      update_en = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      look("rst3c0", 32'h3C0, 1'b0, 1'b0, 32'h0);
      look("rst104", 32'h104, 1'b0, 1'b0, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
